// File: rtl/vlc_cnt_pkg.sv
// Shared counter package: FSM state and count-mode encodings
// used by the timer/counter blocks.
package vlc_cnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_e;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/b_down_timer.sv
// Loadable down-timer with one-shot / periodic reload and
// a single-cycle terminal-count pulse.
module b_down_timer
    import vlc_cnt_pkg::*;
#(
    parameter int C_WIDTH = 10
) (
    input  logic               c_clk,
    input  logic               c_reset,
    input  logic               en,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [C_WIDTH-1:0] load_val,
    output logic [C_WIDTH-1:0] c_out,
    output logic               busy,
    output logic               tc
);

    localparam logic [C_WIDTH-1:0] ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};

    cnt_state_e         state_q, state_d;
    cnt_mode_e          mode_q, mode_d;
    logic [C_WIDTH-1:0] cnt_q, cnt_d;
    logic [C_WIDTH-1:0] reload_q, reload_d;
    logic               busy_q, busy_d;
    logic               tc_q, tc_d;

    always_ff @(posedge c_clk or posedge c_reset) begin
        if (c_reset) begin
            state_q  <= IDLE;
            mode_q   <= ONE_SHOT;
            cnt_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    cnt_d    = load_val;
                    reload_d = load_val;
                    mode_d   = cnt_mode_e'(mode);
                end
            end
            RUN: begin
                // stop wins over a coincident terminal event
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == '0) begin
                        tc_d = 1'b1;
                        if (mode_q == PERIODIC) begin
                            cnt_d = reload_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    assign c_out = cnt_q;
    assign busy  = busy_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_b_down_timer.sv
// Self-checking bench for b_down_timer: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_b_down_timer;

    localparam int W = 10;

    logic         c_clk;
    logic         c_reset;
    logic         en;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] load_val;
    logic [W-1:0] c_out;
    logic         busy;
    logic         tc;

    int total = 0;
    int bad   = 0;

    // reference model: a running flag plus an integer count
    bit m_run;
    int m_cnt;
    int m_rel;
    bit m_per;
    bit m_tc;

    typedef struct {
        bit st;
        bit sp;
        bit md;
        bit en;
        int ld;
        int e_cnt;
        bit e_busy;
        bit e_tc;
    } vec_t;

    vec_t vecs[$];

    b_down_timer #(.C_WIDTH(W)) dut (
        .c_clk    (c_clk),
        .c_reset  (c_reset),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .load_val (load_val),
        .c_out    (c_out),
        .busy     (busy),
        .tc       (tc)
    );

    initial begin
        c_clk = 1'b0;
        forever #5 c_clk = ~c_clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0;
        m_cnt = 0;
        m_rel = 0;
        m_per = 0;
        m_tc  = 0;
    endtask

    task automatic model_edge();
        m_tc = 0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1;
                m_cnt = int'(load_val);
                m_rel = int'(load_val);
                m_per = mode;
            end
        end else if (stop) begin
            m_run = 0;
            m_cnt = 0;
        end else if (en) begin
            if (m_cnt == 0) begin
                m_tc = 1;
                if (m_per) m_cnt = m_rel;
                else m_run = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        if (c_reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".c_out"}, int'(c_out), m_cnt);
        chk({tag, ".busy"}, int'(busy), int'(m_run));
        chk({tag, ".tc"}, int'(tc), int'(m_tc));
    endtask

    task automatic idle_in();
        start = 0;
        stop  = 0;
    endtask

    initial begin
        int n;
        int en_edges;
        int at_tc;
        int prev;
        vec_t v;

        model_reset();
        c_reset  = 1;
        en       = 1;
        start    = 1;
        stop     = 0;
        mode     = 1;
        load_val = 10'd7;

        // start held during reset must not be taken
        step();
        step();
        chk("rst.c_out", int'(c_out), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.tc", int'(tc), 0);
        c_reset = 0;
        start   = 0;
        step();
        chk("post_rst.busy", int'(busy), 0);

        // one-shot 5 and stop/start priority vectors
        vecs.push_back('{1, 0, 0, 1, 5, 5, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 4, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 3, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 2, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 1, 9, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
        foreach (vecs[i]) begin
            v        = vecs[i];
            start    = v.st;
            stop     = v.sp;
            mode     = v.md;
            en       = v.en;
            load_val = W'(v.ld);
            step();
            chk($sformatf("vec%0d.c_out", i), int'(c_out), v.e_cnt);
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(v.e_busy));
            chk($sformatf("vec%0d.tc", i), int'(tc), int'(v.e_tc));
        end
        idle_in();

        // periodic reload of 3 over 20 enabled cycles
        load_val = 10'd3;
        mode     = 1;
        en       = 1;
        start    = 1;
        step();
        start = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cmp_model("per");
            chk("per.busy_hi", int'(busy), 1);
            if (tc) n++;
        end
        chk("per.pulses", n, 5);
        stop = 1;
        step();
        stop = 0;
        chk("per.stopped", int'(busy), 0);

        // enable gating with load 4
        load_val = 10'd4;
        mode     = 0;
        start    = 1;
        step();
        start    = 0;
        en_edges = 0;
        at_tc    = -1;
        for (int i = 0; i < 12; i++) begin
            en   = (i % 2 == 0);
            prev = int'(c_out);
            step();
            if (en) en_edges++;
            if (!en) chk("gate.hold", int'(c_out), prev);
            if (tc) begin
                chk("gate.tc_en", int'(en), 1);
                at_tc = en_edges;
            end
            cmp_model("gate");
        end
        chk("gate.tc_edge", at_tc, 5);
        en = 1;

        // stop coinciding with the terminal edge
        load_val = 10'd2;
        start    = 1;
        step();
        start = 0;
        step();
        step();
        chk("abort.at0", int'(c_out), 0);
        stop = 1;
        step();
        stop = 0;
        chk("abort.tc", int'(tc), 0);
        chk("abort.c_out", int'(c_out), 0);
        chk("abort.busy", int'(busy), 0);
        step();
        chk("abort.tc2", int'(tc), 0);
        start    = 1;
        stop     = 1;
        load_val = 10'd6;
        step();
        idle_in();
        chk("startstop.busy", int'(busy), 0);
        chk("startstop.c_out", int'(c_out), 0);

        // load 0 periodic: tc on every enabled edge
        load_val = 10'd0;
        mode     = 1;
        start    = 1;
        step();
        start = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("zero.tc", int'(tc), 1);
            cmp_model("zero");
        end
        stop = 1;
        step();
        stop = 0;

        // full-scale one-shot, with a start ignored mid-run
        load_val = 10'd1023;
        mode     = 0;
        start    = 1;
        step();
        start = 0;
        n     = 0;
        at_tc = -1;
        for (int i = 0; i < 1100 && at_tc < 0; i++) begin
            if (i == 10) begin
                start    = 1;
                load_val = 10'd5;
                mode     = 1;
            end else begin
                start = 0;
            end
            step();
            n++;
            if (i == 10) chk("max.ign", int'(c_out), 1023 - 11);
            cmp_model("max");
            if (tc) at_tc = n;
        end
        chk("max.tc_edge", at_tc, 1024);
        step();
        chk("max.idle", int'(busy), 0);

        // asynchronous reset mid-count
        load_val = 10'd10;
        mode     = 0;
        start    = 1;
        step();
        start = 0;
        for (int i = 0; i < 20 && c_out != 10'd7; i++) step();
        chk("arst.at7", int'(c_out), 7);
        #1 c_reset = 1;
        #1;
        model_reset();
        chk("arst.c_out", int'(c_out), 0);
        chk("arst.busy", int'(busy), 0);
        chk("arst.tc", int'(tc), 0);
        #1 c_reset = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp_model("arst_idle");
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 3) != 0);
            mode     = 1'($urandom_range(0, 1));
            load_val = W'($urandom_range(0, 12));
            step();
            cmp_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
